mem_bus_responder: RTL and testbench

Memory-bus responder serving the CPU's `start`/`we`/`address`/`data` → `q`/`busy` interface. It decodes the 27-bit word address into on-chip RAM, a small I/O register bank, and an external slow port with a req/ack handshake and timeout. `busy` is held high until the access completes, and `q` returns read data. It sits between the CPU core and all memory-mapped targets.

---
 rtl/mem_bus_pkg.sv | 37 +++
 rtl/resp_ram.sv | 26 ++
 rtl/mem_bus_responder.sv | 157 +++++++++++++++
 tb/tb_mem_bus_responder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU memory-bus responder.
package mem_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAM,
    ST_IO,
    ST_EXT,
    ST_DONE
  } state_t;

  localparam logic [2:0] REG_RAM = 3'd0;
  localparam logic [2:0] REG_IO  = 3'd1;

  localparam logic [1:0] IO_SCR0 = 2'd0;
  localparam logic [1:0] IO_SCR1 = 2'd1;
  localparam logic [1:0] IO_SCR2 = 2'd2;
  localparam logic [1:0] IO_CNT  = 2'd3;

  localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

  // Only the fields still needed after acceptance are kept.
  typedef struct packed {
    logic        we;
    logic [1:0]  io_idx;
    logic [31:0] data;
  } req_t;

  function automatic state_t region_state(input logic [2:0] region);
    case (region)
      REG_RAM: return ST_RAM;
      REG_IO:  return ST_IO;
      default: return ST_EXT;
    endcase
  endfunction

endpackage

// File: rtl/resp_ram.sv
// Single-port synchronous RAM, one-cycle read latency, write-first.
module resp_ram #(
  parameter int RAM_AW = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**RAM_AW];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata     <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// CPU memory-bus responder: decodes word address into on-chip RAM,
// an IO register bank and an external req/ack port with timeout.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int RAM_AW   = 10,
  parameter int RAM_WAIT = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        we,
  input  logic [26:0] address,
  input  logic [31:0] data,
  output logic [31:0] q,
  output logic        busy,
  output logic        ext_req,
  output logic        ext_we,
  output logic [23:0] ext_addr,
  output logic [31:0] ext_data,
  input  logic [31:0] ext_q,
  input  logic        ext_ack,
  output logic        bus_err
);

  localparam logic [9:0] RAM_LAST = 10'(RAM_WAIT);
  localparam logic [9:0] EXT_LAST = 10'(TIMEOUT);

  state_t      state, state_nxt;
  req_t        req_q;
  logic [9:0]  cnt;
  logic        accept;
  logic        leave;
  logic        ext_timeout;
  logic [31:0] ram_rdata;
  logic [31:0] io_rdata;
  logic [2:0][31:0] scratch;
  logic [31:0] txn_cnt;

  assign accept = (state == ST_IDLE) && start;

  // RAM is addressed straight from the bus on acceptance, so the registered
  // array output is already settled by the last RAM cycle even with zero wait.
  resp_ram #(.RAM_AW(RAM_AW)) u_ram (
    .clk   (clk),
    .en    (accept && (address[26:24] == REG_RAM)),
    .we    (we),
    .addr  (address[RAM_AW-1:0]),
    .wdata (data),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_nxt   = state;
    ext_timeout = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = region_state(address[26:24]);
      ST_RAM:  if (cnt == RAM_LAST) state_nxt = ST_DONE;
      ST_IO:   state_nxt = ST_DONE;
      ST_EXT: begin
        if (ext_ack) begin
          state_nxt = ST_DONE;
        end else if (cnt == EXT_LAST) begin
          state_nxt   = ST_DONE;
          ext_timeout = 1'b1;
        end
      end
      ST_DONE: if (!start) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign leave = (state != ST_DONE) && (state_nxt == ST_DONE);

  always_comb begin
    io_rdata = txn_cnt;
    case (req_q.io_idx)
      IO_SCR0: io_rdata = scratch[0];
      IO_SCR1: io_rdata = scratch[1];
      IO_SCR2: io_rdata = scratch[2];
      default: io_rdata = txn_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        cnt <= '0;
      else if (state == ST_RAM || state == ST_EXT)
        cnt <= cnt + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q    <= '0;
      busy     <= 1'b0;
      q        <= '0;
      ext_req  <= 1'b0;
      ext_we   <= 1'b0;
      ext_addr <= '0;
      ext_data <= '0;
      bus_err  <= 1'b0;
    end else begin
      busy    <= (state_nxt == ST_RAM) || (state_nxt == ST_IO) ||
                 (state_nxt == ST_EXT);
      bus_err <= (state == ST_EXT) && ext_timeout;
      if (accept) begin
        req_q.we     <= we;
        req_q.io_idx <= address[1:0];
        req_q.data   <= data;
        if (state_nxt == ST_EXT) begin
          ext_req  <= 1'b1;
          ext_we   <= we;
          ext_addr <= address[23:0];
          ext_data <= data;
        end
      end
      if (state == ST_EXT && leave) begin
        ext_req <= 1'b0;
        ext_we  <= 1'b0;
      end
      if (leave && !req_q.we) begin
        case (state)
          ST_RAM:  q <= ram_rdata;
          ST_IO:   q <= io_rdata;
          ST_EXT:  q <= ext_ack ? ext_q : ERR_DATA;
          default: q <= q;
        endcase
      end
    end
  end

  // Register 3 is the completed-transaction count; writes to it are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scratch <= '0;
      txn_cnt <= '0;
    end else begin
      if (leave) txn_cnt <= txn_cnt + 32'd1;
      if (state == ST_IO && req_q.we) begin
        case (req_q.io_idx)
          IO_SCR0: scratch[0] <= req_q.data;
          IO_SCR1: scratch[1] <= req_q.data;
          IO_SCR2: scratch[2] <= req_q.data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: vector table plus multi-cycle sequences.
module tb_mem_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, we;
  logic [26:0] address;
  logic [31:0] data;
  logic [31:0] q;
  logic        busy, ext_req, ext_we, bus_err;
  logic [23:0] ext_addr;
  logic [31:0] ext_data, ext_q;
  logic        ext_ack;

  int n_cmp = 0;
  int n_bad = 0;

  mem_bus_responder #(.RAM_AW(10), .RAM_WAIT(1), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .start(start), .we(we), .address(address),
    .data(data), .q(q), .busy(busy), .ext_req(ext_req), .ext_we(ext_we),
    .ext_addr(ext_addr), .ext_data(ext_data), .ext_q(ext_q),
    .ext_ack(ext_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [26:0] addr;
    logic [31:0] data;
    int          nb;
    logic [31:0] q;
  } vec_t;

  vec_t vt[15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One transaction from IDLE: start for one cycle, count busy cycles,
  // return q at the busy-fall cycle, then step back to IDLE.
  task automatic do_txn(input logic w, input logic [26:0] a, input logic [31:0] d,
                        output int nb, output logic [31:0] qo);
    start = 1'b1; we = w; address = a; data = d;
    tick();
    start = 1'b0;
    nb = 0;
    while (busy && nb < 200) begin
      nb++;
      tick();
    end
    qo = q;
    tick();
  endtask

  initial begin
    int nb, errs;
    logic [31:0] qo;

    vt[0]  = '{1'b1, 27'h1000001, 32'hA5A5_A5A5, 1, 32'h0000_0000};
    vt[1]  = '{1'b0, 27'h1000003, 32'h0,         1, 32'h0000_0001};
    vt[2]  = '{1'b1, 27'h1000003, 32'hFFFF_0000, 1, 32'h0000_0001};
    vt[3]  = '{1'b0, 27'h1000003, 32'h0,         1, 32'h0000_0003};
    vt[4]  = '{1'b0, 27'h1000001, 32'h0,         1, 32'hA5A5_A5A5};
    vt[5]  = '{1'b1, 27'h1FFFFF6, 32'h1111_2222, 1, 32'hA5A5_A5A5};
    vt[6]  = '{1'b0, 27'h1000002, 32'h0,         1, 32'h1111_2222};
    vt[7]  = '{1'b0, 27'h1000000, 32'h0,         1, 32'h0000_0000};
    vt[8]  = '{1'b1, 27'h0000005, 32'h1234_5678, 2, 32'h0000_0000};
    vt[9]  = '{1'b0, 27'h0000005, 32'h0,         2, 32'h1234_5678};
    vt[10] = '{1'b1, 27'h0000405, 32'hDEAD_BEEF, 2, 32'h1234_5678};
    vt[11] = '{1'b0, 27'h0000005, 32'h0,         2, 32'hDEAD_BEEF};
    vt[12] = '{1'b1, 27'h00003FF, 32'h0BAD_F00D, 2, 32'hDEAD_BEEF};
    vt[13] = '{1'b0, 27'h0FFFFFF, 32'h0,         2, 32'h0BAD_F00D};
    vt[14] = '{1'b0, 27'h1000003, 32'h0,         1, 32'h0000_000E};

    reset = 1'b0; start = 1'b0; we = 1'b0; address = '0; data = '0;
    ext_q = '0; ext_ack = 1'b0;
    tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_q", q, 32'd0);
    check("rst_ext", {ext_req, ext_we, bus_err, ext_addr}, 27'd0);
    check("rst_ext_data", ext_data, 32'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) begin
      do_txn(vt[i].we, vt[i].addr, vt[i].data, nb, qo);
      check($sformatf("vec%0d_busy_cycles", i), nb, vt[i].nb);
      check($sformatf("vec%0d_q", i), qo, vt[i].q);
    end

    // EXT read, ack on the 4th ext_req cycle
    start = 1'b1; we = 1'b0; address = 27'h2000010;
    tick();
    start = 1'b0;
    check("ext_rd_req", {31'd0, ext_req}, 32'd1);
    check("ext_rd_addr", {8'd0, ext_addr}, 32'h0000_0010);
    check("ext_rd_we", {31'd0, ext_we}, 32'd0);
    tick(); tick(); tick();
    check("ext_rd_req_c4", {31'd0, ext_req}, 32'd1);
    ext_ack = 1'b1; ext_q = 32'hCAFE_0001;
    tick();
    ext_ack = 1'b0;
    check("ext_rd_busy_fall", {31'd0, busy}, 32'd0);
    check("ext_rd_q", q, 32'hCAFE_0001);
    check("ext_rd_req_drop", {31'd0, ext_req}, 32'd0);
    check("ext_rd_no_err", {31'd0, bus_err}, 32'd0);
    tick();

    // Stray ack while idle must not do anything
    ext_ack = 1'b1; ext_q = 32'h1212_1212;
    tick(); tick();
    ext_ack = 1'b0;
    check("idle_ack_busy", {31'd0, busy}, 32'd0);
    check("idle_ack_q", q, 32'hCAFE_0001);

    // EXT write, ack in the first cycle; q untouched
    start = 1'b1; we = 1'b1; address = 27'h7ABCDEF; data = 32'h55AA_55AA;
    tick();
    start = 1'b0;
    check("ext_wr_strobe", {30'd0, ext_req, ext_we}, 32'd3);
    check("ext_wr_addr", {8'd0, ext_addr}, 32'h00AB_CDEF);
    check("ext_wr_data", ext_data, 32'h55AA_55AA);
    ext_ack = 1'b1; ext_q = 32'h9999_9999;
    tick();
    ext_ack = 1'b0;
    check("ext_wr_busy_fall", {31'd0, busy}, 32'd0);
    check("ext_wr_q_kept", q, 32'hCAFE_0001);
    tick();

    // EXT read timeout (TIMEOUT=8): busy T+1..T+9
    start = 1'b1; we = 1'b0; address = 27'h3000020;
    tick();
    start = 1'b0;
    nb = 0; errs = 0;
    while (busy && nb < 50) begin
      nb++;
      errs += int'(bus_err);
      tick();
    end
    check("to_busy_cycles", nb, 9);
    check("to_err_early", errs, 0);
    check("to_q", q, 32'hFFFF_FFFF);
    check("to_err_pulse", {31'd0, bus_err}, 32'd1);
    tick();
    check("to_err_one_cycle", {31'd0, bus_err}, 32'd0);

    // Ack arriving in the timeout cycle wins
    start = 1'b1; we = 1'b0; address = 27'h4000001;
    tick();
    start = 1'b0;
    repeat (8) tick();
    check("ackto_busy", {31'd0, busy}, 32'd1);
    ext_ack = 1'b1; ext_q = 32'h0000_BEEF;
    tick();
    ext_ack = 1'b0;
    check("ackto_busy_fall", {31'd0, busy}, 32'd0);
    check("ackto_q", q, 32'h0000_BEEF);
    check("ackto_no_err", {31'd0, bus_err}, 32'd0);
    tick();

    // start held 20 cycles on an IO read of the counter: one transaction only
    start = 1'b1; we = 1'b0; address = 27'h1000003;
    nb = 0;
    repeat (20) begin
      tick();
      if (busy) nb++;
    end
    check("hold_busy_cycles", nb, 1);
    check("hold_q", q, 32'd19);
    start = 1'b0;
    tick();
    do_txn(1'b0, 27'h1000003, 32'h0, nb, qo);
    check("hold_cnt_after", qo, 32'd20);

    // Reset during an EXT wait
    start = 1'b1; we = 1'b0; address = 27'h5000000;
    tick();
    start = 1'b0;
    tick(); tick();
    #2 reset = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_req", {31'd0, ext_req}, 32'd0);
    tick();
    check("arst_no_err", {31'd0, bus_err}, 32'd0);
    check("arst_q", q, 32'd0);
    reset = 1'b1;
    tick();
    do_txn(1'b0, 27'h0000005, 32'h0, nb, qo);
    check("post_rst_ram_busy", nb, 2);
    check("post_rst_ram_q", qo, 32'hDEAD_BEEF);
    do_txn(1'b0, 27'h1000003, 32'h0, nb, qo);
    check("post_rst_cnt", qo, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
